// File: rtl/iob_prio_dec_pkg.sv
// Shared defaults and buffer-state encoding for the streaming priority decoder.
package iob_prio_dec_pkg;

  localparam int    IOB_PRIO_DEC_W     = 8;
  localparam string IOB_PRIO_DEC_MODE  = "LOW";
  localparam int    IOB_PRIO_DEC_CNT_W = 16;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/iob_prio_dec_skid.sv
// Generic 2-entry valid/ready skid buffer with a registered ready output.
module iob_prio_dec_skid
  import iob_prio_dec_pkg::*;
#(
  parameter int DATA_W = 17
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  buf_state_t        r_state;
  buf_state_t        w_state_nx;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nx;
  logic [DATA_W-1:0] w_skid_nx;
  logic              r_ready;
  logic              w_acc;
  logic              w_pop;

  assign w_acc       = in_valid_i && r_ready;
  assign w_pop       = (r_state != ST_EMPTY) && out_ready_i;
  assign in_ready_o  = r_ready;
  assign out_valid_o = (r_state != ST_EMPTY);
  assign out_data_o  = r_main;

  // Next-state and data steering: main holds the head beat, skid catches one extra.
  always_comb begin
    w_state_nx = r_state;
    w_main_nx  = r_main;
    w_skid_nx  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nx = ST_ONE;
          w_main_nx  = in_data_i;
        end
      end
      ST_ONE: begin
        if (w_acc && w_pop) begin
          w_main_nx = in_data_i;
        end else if (w_acc) begin
          w_state_nx = ST_FULL;
          w_skid_nx  = in_data_i;
        end else if (w_pop) begin
          w_state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_state_nx = ST_ONE;
          w_main_nx  = r_skid;
        end
      end
      default: w_state_nx = ST_EMPTY;
    endcase
  end

  // State and data registers; ready is precomputed so it never depends on out_ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (cke_i) begin
      r_state <= w_state_nx;
      r_ready <= (w_state_nx != ST_FULL);
      r_main  <= w_main_nx;
      r_skid  <= w_skid_nx;
    end
  end

endmodule

// File: rtl/iob_prio_dec.sv
// Streaming priority decoder: index in, registered one-hot plus priority mask out.
module iob_prio_dec
  import iob_prio_dec_pkg::*;
#(
  parameter int    W     = IOB_PRIO_DEC_W,
  parameter string MODE  = IOB_PRIO_DEC_MODE,
  parameter int    CNT_W = IOB_PRIO_DEC_CNT_W,
  localparam int   IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IDX_W-1:0] in_encoded_i,
  input  logic             in_zero_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_onehot_o,
  output logic [W-1:0]     out_mask_o,
  output logic             out_range_err_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] count_o
);

  localparam bit IS_LOW = (MODE == "LOW");
  localparam int DATA_W = 2 * W + 1;

  // Packed as {err, mask, onehot} so the buffer stays a plain data pipe.
  function automatic logic [DATA_W-1:0] decode(input logic [IDX_W-1:0] idx,
                                               input logic             zero);
    logic [W-1:0] oh;
    logic [W-1:0] mk;
    logic         err;
    oh  = '0;
    mk  = '0;
    err = 1'b0;
    if (!zero) begin
      if (int'(idx) >= W) begin
        err = 1'b1;
      end else begin
        for (int k = 0; k < W; k++) begin
          oh[k] = (k == int'(idx));
          mk[k] = IS_LOW ? (k >= int'(idx)) : (k <= int'(idx));
        end
      end
    end
    return {err, mk, oh};
  endfunction

  logic [DATA_W-1:0] w_dec;
  logic [DATA_W-1:0] w_out_data;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_acc;
  logic              w_pop;
  logic              r_err_sticky;
  logic [CNT_W-1:0]  r_count;

  assign w_dec = decode(in_encoded_i, in_zero_i);

  iob_prio_dec_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk_i      (clk_i),
    .cke_i      (cke_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (w_in_ready),
    .in_data_i  (w_dec),
    .out_valid_o(w_out_valid),
    .out_ready_i(out_ready_i),
    .out_data_o (w_out_data)
  );

  assign w_acc = in_valid_i && w_in_ready;
  assign w_pop = w_out_valid && out_ready_i;

  assign in_ready_o      = w_in_ready;
  assign out_valid_o     = w_out_valid;
  assign out_onehot_o    = w_out_data[W-1:0];
  assign out_mask_o      = w_out_data[2*W-1:W];
  assign out_range_err_o = w_out_data[2*W];
  assign err_sticky_o    = r_err_sticky;
  assign count_o         = r_count;

  // Sticky range error and wrapping count of completed output handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_sticky <= 1'b0;
      r_count      <= '0;
    end else if (cke_i) begin
      if (w_acc && w_dec[2*W]) begin
        r_err_sticky <= 1'b1;
      end
      if (w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_iob_prio_dec.sv
// Directed self-checking bench: four decoder variants driven by one shared stream.
module tb_iob_prio_dec;

  logic       clk = 1'b0;
  logic       cke, rst, in_valid, in_zero, out_ready;
  logic [2:0] in_idx;

  logic       lo_rdy, lo_vld, lo_err, lo_stk;
  logic [7:0] lo_oh, lo_mk;
  logic [15:0] lo_cnt;
  logic       hi_rdy, hi_vld, hi_err, hi_stk;
  logic [7:0] hi_oh, hi_mk;
  logic [15:0] hi_cnt;
  logic       w5_rdy, w5_vld, w5_err, w5_stk;
  logic [4:0] w5_oh, w5_mk;
  logic [15:0] w5_cnt;
  logic       c2_rdy, c2_vld, c2_err, c2_stk;
  logic [7:0] c2_oh, c2_mk;
  logic [1:0] c2_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iob_prio_dec #(.W(8), .MODE("LOW"), .CNT_W(16)) u_lo (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(lo_rdy),
    .in_encoded_i(in_idx), .in_zero_i(in_zero), .out_valid_o(lo_vld), .out_ready_i(out_ready),
    .out_onehot_o(lo_oh), .out_mask_o(lo_mk), .out_range_err_o(lo_err),
    .err_sticky_o(lo_stk), .count_o(lo_cnt));

  iob_prio_dec #(.W(8), .MODE("HIGH"), .CNT_W(16)) u_hi (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(hi_rdy),
    .in_encoded_i(in_idx), .in_zero_i(in_zero), .out_valid_o(hi_vld), .out_ready_i(out_ready),
    .out_onehot_o(hi_oh), .out_mask_o(hi_mk), .out_range_err_o(hi_err),
    .err_sticky_o(hi_stk), .count_o(hi_cnt));

  iob_prio_dec #(.W(5), .MODE("LOW"), .CNT_W(16)) u_w5 (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(w5_rdy),
    .in_encoded_i(in_idx), .in_zero_i(in_zero), .out_valid_o(w5_vld), .out_ready_i(out_ready),
    .out_onehot_o(w5_oh), .out_mask_o(w5_mk), .out_range_err_o(w5_err),
    .err_sticky_o(w5_stk), .count_o(w5_cnt));

  iob_prio_dec #(.W(8), .MODE("LOW"), .CNT_W(2)) u_c2 (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(c2_rdy),
    .in_encoded_i(in_idx), .in_zero_i(in_zero), .out_valid_o(c2_vld), .out_ready_i(out_ready),
    .out_onehot_o(c2_oh), .out_mask_o(c2_mk), .out_range_err_o(c2_err),
    .err_sticky_o(c2_stk), .count_o(c2_cnt));

  // Reference priority encoders used for the round-trip property.
  function automatic int enc_low(input logic [7:0] m);
    for (int k = 0; k < 8; k++) if (m[k]) return k;
    return -1;
  endfunction

  function automatic int enc_high(input logic [7:0] m);
    for (int k = 7; k >= 0; k--) if (m[k]) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectations for the index sweep.
  logic [7:0] lo_mask_tab [8] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
  logic [7:0] hi_mask_tab [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
  logic [4:0] w5_mask_tab [8] = '{5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h10, 5'h00, 5'h00, 5'h00};
  logic [4:0] w5_oh_tab   [8] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};

  initial begin
    cke = 1'b1; rst = 1'b1; in_valid = 1'b0; in_zero = 1'b0; in_idx = 3'd0; out_ready = 1'b1;
    step(); step();
    chk("rst_ready", 32'(lo_rdy), 32'd1);
    chk("rst_valid", 32'(lo_vld), 32'd0);
    chk("rst_onehot", 32'(lo_oh), 32'h0);
    chk("rst_mask", 32'(lo_mk), 32'h0);
    chk("rst_err", 32'(lo_err), 32'd0);
    chk("rst_sticky", 32'(lo_stk), 32'd0);
    chk("rst_count", 32'(lo_cnt), 32'd0);
    rst = 1'b0;
    step();

    // Single beat, idx 3.
    in_valid = 1'b1; in_idx = 3'd3;
    step();
    in_valid = 1'b0;
    chk("t1_valid", 32'(lo_vld), 32'd1);
    chk("t1_onehot", 32'(lo_oh), 32'h08);
    chk("t1_mask_low", 32'(lo_mk), 32'hF8);
    chk("t1_err", 32'(lo_err), 32'd0);
    chk("t1_mask_high", 32'(hi_mk), 32'h0F);
    step();
    chk("t1_count", 32'(lo_cnt), 32'd1);
    chk("t1_drained", 32'(lo_vld), 32'd0);

    // Back-to-back sweep of every index, full throughput.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_idx = 3'(i);
      step();
      chk("sw_ready", 32'(lo_rdy), 32'd1);
      chk("sw_onehot", 32'(lo_oh), 32'(8'h01 << i));
      chk("sw_mask_low", 32'(lo_mk), 32'(lo_mask_tab[i]));
      chk("sw_mask_high", 32'(hi_mk), 32'(hi_mask_tab[i]));
      chk("sw_rt_low", 32'(enc_low(lo_mk)), 32'(i));
      chk("sw_rt_high", 32'(enc_high(hi_mk)), 32'(i));
      chk("sw_w5_onehot", 32'(w5_oh), 32'(w5_oh_tab[i]));
      chk("sw_w5_mask", 32'(w5_mk), 32'(w5_mask_tab[i]));
      chk("sw_w5_err", 32'(w5_err), (i >= 5) ? 32'd1 : 32'd0);
      if (i == 4) chk("c2_count_5pops", 32'(c2_cnt), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("sw_count", 32'(lo_cnt), 32'd9);
    chk("sw_c2_count", 32'(c2_cnt), 32'd1);
    chk("sw_w5_sticky", 32'(w5_stk), 32'd1);
    chk("sw_lo_sticky", 32'(lo_stk), 32'd0);

    // Out-of-range on W=5 after a clearing reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t3_sticky_clr", 32'(w5_stk), 32'd0);
    chk("t3_count_clr", 32'(lo_cnt), 32'd0);
    in_valid = 1'b1; in_idx = 3'd6;
    step();
    chk("t3_onehot", 32'(w5_oh), 32'h0);
    chk("t3_mask", 32'(w5_mk), 32'h0);
    chk("t3_err", 32'(w5_err), 32'd1);
    chk("t3_sticky", 32'(w5_stk), 32'd1);
    in_idx = 3'd2;
    step();
    in_valid = 1'b0;
    chk("t3b_err", 32'(w5_err), 32'd0);
    chk("t3b_onehot", 32'(w5_oh), 32'h04);
    chk("t3b_mask", 32'(w5_mk), 32'h1C);
    chk("t3b_sticky", 32'(w5_stk), 32'd1);
    step();

    // Backpressure: fill to FULL, then release.
    out_ready = 1'b0;
    in_valid = 1'b1; in_idx = 3'd1;
    step();
    chk("bp_ready1", 32'(lo_rdy), 32'd1);
    in_idx = 3'd2;
    step();
    chk("bp_ready_full", 32'(lo_rdy), 32'd0);
    chk("bp_hold1", 32'(lo_oh), 32'h02);
    in_idx = 3'd3;
    step();
    chk("bp_ready_full2", 32'(lo_rdy), 32'd0);
    chk("bp_hold2", 32'(lo_oh), 32'h02);
    chk("bp_valid", 32'(lo_vld), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_out2", 32'(lo_oh), 32'h04);
    step();
    in_valid = 1'b0;
    chk("bp_out3", 32'(lo_oh), 32'h08);
    chk("bp_valid3", 32'(lo_vld), 32'd1);
    step();
    chk("bp_empty", 32'(lo_vld), 32'd0);
    chk("bp_count", 32'(lo_cnt), 32'd5);
    chk("bp_c2_count", 32'(c2_cnt), 32'd1);

    // Zero beat.
    in_valid = 1'b1; in_zero = 1'b1; in_idx = 3'd4;
    step();
    in_valid = 1'b0; in_zero = 1'b0;
    chk("z_valid", 32'(lo_vld), 32'd1);
    chk("z_onehot", 32'(lo_oh), 32'h0);
    chk("z_mask", 32'(lo_mk), 32'h0);
    chk("z_err", 32'(lo_err), 32'd0);
    chk("z_mask_high", 32'(hi_mk), 32'h0);
    step();
    chk("z_count", 32'(lo_cnt), 32'd6);

    // Clock-enable freeze mid-stream.
    in_valid = 1'b1; in_idx = 3'd6;
    step();
    chk("ck_onehot", 32'(lo_oh), 32'h40);
    cke = 1'b0; in_idx = 3'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ck_frz_onehot", 32'(lo_oh), 32'h40);
      chk("ck_frz_count", 32'(lo_cnt), 32'd6);
      chk("ck_frz_valid", 32'(lo_vld), 32'd1);
    end
    cke = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ck_resume_onehot", 32'(lo_oh), 32'h02);
    chk("ck_resume_count", 32'(lo_cnt), 32'd7);
    step();
    chk("ck_count", 32'(lo_cnt), 32'd8);

    // Reset while FULL flushes both entries; a pop under reset is not counted.
    out_ready = 1'b0;
    in_valid = 1'b1; in_idx = 3'd1;
    step();
    in_idx = 3'd2;
    step();
    chk("fr_full", 32'(lo_rdy), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("fr_valid", 32'(lo_vld), 32'd0);
    chk("fr_ready", 32'(lo_rdy), 32'd1);
    chk("fr_count", 32'(lo_cnt), 32'd0);
    chk("fr_sticky", 32'(w5_stk), 32'd0);
    chk("fr_onehot", 32'(lo_oh), 32'h0);
    step();
    chk("fr_stays_empty", 32'(lo_vld), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iob_prio_dec.md
Name: iob_prio_dec

Overview:
- Streaming priority decoder; the inverse of the priority-encoder function in the same codebase.
- Accepts a binary bit-position index over a valid/ready stream and emits a registered one-hot vector plus a priority mask.
- The mask is chosen so that priority-encoding it with the same MODE returns the original index.
- Sits between arbitration/scheduling logic that passes compact indices and the per-line grant/enable vectors that consume them. A 2-entry skid buffer gives full throughput with a registered ready.

Parameters:
- W, 8: number of decoded lines; any value >= 2, power of 2 not required.
- MODE, "LOW": "LOW" gives mask bits [W-1:idx] set. Any other value (nominally "HIGH") gives mask bits [idx:0] set.
- CNT_W, 16: width of the decoded-beat counter.

Ports:
- clk_i  input  1  system clock, rising edge.
- cke_i  input  1  clock enable; when low, all state holds.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  input beat accepted when in_valid_i && in_ready_o && cke_i.
- in_encoded_i  input  $clog2(W)  bit-position index.
- in_zero_i  input  1  beat represents "no bit set"; in_encoded_i is ignored.
- out_valid_o  output  1  output beat valid.
- out_ready_i  input  1  downstream accepts the beat.
- out_onehot_o  output  W  one-hot decode of the index.
- out_mask_o  output  W  priority mask, per MODE.
- out_range_err_o  output  1  index of this beat was >= W.
- err_sticky_o  output  1  set by any accepted out-of-range input beat; cleared only by rst_i.
- count_o  output  CNT_W  number of completed output handshakes, wrapping.

Behaviour:
- Clock, clock enable and reset are one clock (clk_i), synchronous active-high reset (rst_i), and clock enable cke_i. All registers update only when cke_i=1.
- Reset values: in_ready_o=1, out_valid_o=0, out_onehot_o=0, out_mask_o=0, out_range_err_o=0, err_sticky_o=0, count_o=0.
- Reset mid-operation flushes both buffer entries; beats held there are dropped.
- Decode function (combinational, applied at input accept):
  - in_zero_i=1: onehot=0, mask=0, err=0.
  - idx >= W, possible only when W is not a power of 2: onehot=0, mask=0, err=1.
  - Otherwise onehot[idx]=1. LOW: mask[k]=1 for k>=idx. HIGH: mask[k]=1 for k<=idx. err=0.
  - Decoded fields are stored, not the raw index.
- Buffer states:
  - EMPTY: out_valid_o=0, in_ready_o=1.
  - ONE: main register valid, out_valid_o=1, in_ready_o=1.
  - FULL: main and skid registers valid, in_ready_o=0.
- Transitions (acc = input handshake, pop = out_valid_o && out_ready_i):
  - EMPTY + acc -> ONE; beat goes to main.
  - ONE + acc, no pop -> FULL; beat goes to skid.
  - ONE + acc + pop -> ONE; new beat goes to main.
  - ONE + pop, no acc -> EMPTY.
  - FULL + pop -> ONE; skid moves to main.
  - FULL never accepts, since in_ready_o=0.
- Latency: a beat accepted in cycle N appears on the outputs in cycle N+1 if the buffer was EMPTY, or directly behind earlier beats otherwise. Throughput is 1 beat/cycle with out_ready_i held high.
- in_ready_o is a register output; there is no combinational path from out_ready_i.
- Outputs are stable while out_valid_o=1 && out_ready_i=0.
- err_sticky_o sets in the cycle after an accepted out-of-range beat.
- count_o increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- A beat popped in the same cycle as rst_i=1 is not counted.

Decomposition:
- Shared package/header iob_prio_dec_conf.vh holds the defaults: IOB_PRIO_DEC_W, IOB_PRIO_DEC_MODE, IOB_PRIO_DEC_CNT_W.
- The buffer state encodings (EMPTY=0, ONE=1, FULL=2) are localparams in the same header.
- One natural sub-module: iob_prio_dec_skid, a generic 2-entry valid/ready skid buffer parameterised on DATA_W.
  - Instantiated here with DATA_W=2*W+1 (onehot, mask, err).
  - The decode function and counter stay in the top module.

Test Plan:
1. W=8, LOW, out_ready_i=1: in_encoded_i=3 accepted in cycle N -> in cycle N+1 out_onehot_o=8'h08, out_mask_o=8'hF8, out_range_err_o=0, and count_o=1 one cycle later.
2. W=8, MODE="HIGH", idx=5 -> out_mask_o=8'h3F. Feed the mask to iob_prio_enc with MODE="HIGH" -> encoded_o=5. Sweep idx=0..7 for both modes; the round-trip must hold for every value.
3. W=5, LOW, idx=6 -> out_onehot_o=0, out_mask_o=0, out_range_err_o=1, err_sticky_o=1 from the next cycle onward. A following valid idx=2 -> out_range_err_o=0 while err_sticky_o stays 1.
4. Backpressure:
   - out_ready_i=0 with indices 1,2,3 offered back-to-back -> beats 1 and 2 accepted, then in_ready_o=0, and out_onehot_o holds 8'h02.
   - Release out_ready_i -> outputs 8'h02, 8'h04, 8'h08 in order, with no loss or duplication.
5. in_zero_i=1 with in_encoded_i=4 -> out_onehot_o=0, out_mask_o=0, out_range_err_o=0, count_o increments on pop.
6. Control events:
   - FULL buffer, then rst_i=1 for 1 cycle -> next cycle out_valid_o=0, in_ready_o=1, count_o=0, err_sticky_o=0.
   - cke_i=0 for 3 cycles mid-stream -> all outputs and count_o frozen.
   - CNT_W=2: 5 pops -> count_o=1.
